// File: rtl/comparator_if.sv
// Operand/result bundle for the comparator; the comparator takes the slave side.
// With COMPARATOR_MINMAX_EN defined the bundle also carries the registered min_q/max_q.
interface comparator_if #(
   parameter int N = 3
);
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         in_valid;
   logic         lt;
   logic         eq;
   logic         gt;
   logic         lt_q;
   logic         eq_q;
   logic         gt_q;
   logic         out_valid;
`ifdef COMPARATOR_MINMAX_EN
   logic [N-1:0] min_q;
   logic [N-1:0] max_q;

   modport master (
      output a, b, in_valid,
      input  lt, eq, gt, lt_q, eq_q, gt_q, out_valid, min_q, max_q
   );

   modport slave (
      input  a, b, in_valid,
      output lt, eq, gt, lt_q, eq_q, gt_q, out_valid, min_q, max_q
   );
`else
   modport master (
      output a, b, in_valid,
      input  lt, eq, gt, lt_q, eq_q, gt_q, out_valid
   );

   modport slave (
      input  a, b, in_valid,
      output lt, eq, gt, lt_q, eq_q, gt_q, out_valid
   );
`endif
endinterface

// File: rtl/comparator.sv
// comparator: N-bit magnitude compare with combinational lt/eq/gt and a one-cycle registered copy.
// Optional COMPARATOR_MINMAX_EN adds registered min_q/max_q of the captured operands.
module comparator #(
   parameter int N      = 3,
   parameter bit SIGNED = 1'b0
) (
   input logic         clk,
   input logic         rst_n,
   comparator_if.slave bus
);
   localparam logic [N-1:0] ONE       = N'(1);
   localparam logic [N-1:0] SIGN_FLIP = SIGNED ? (ONE << (N - 1)) : '0;

   logic [N-1:0] aKey;
   logic [N-1:0] bKey;
   logic         lt;
   logic         eq;
   logic         gt;
   logic         ltQ;
   logic         eqQ;
   logic         gtQ;
   logic         validQ;

   // Inverting the sign bit maps two's-complement ordering onto unsigned ordering.
   assign aKey = bus.a ^ SIGN_FLIP;
   assign bKey = bus.b ^ SIGN_FLIP;

   assign lt = (aKey < bKey);
   assign eq = (bus.a == bus.b);
   assign gt = (aKey > bKey);

   assign bus.lt        = lt;
   assign bus.eq        = eq;
   assign bus.gt        = gt;
   assign bus.lt_q      = ltQ;
   assign bus.eq_q      = eqQ;
   assign bus.gt_q      = gtQ;
   assign bus.out_valid = validQ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ltQ    <= 1'b0;
         eqQ    <= 1'b0;
         gtQ    <= 1'b0;
         validQ <= 1'b0;
      end else begin
         validQ <= bus.in_valid;
         if (bus.in_valid) begin
            ltQ <= lt;
            eqQ <= eq;
            gtQ <= gt;
         end
      end
   end

`ifdef COMPARATOR_MINMAX_EN
   logic [N-1:0] minQ;
   logic [N-1:0] maxQ;

   assign bus.min_q = minQ;
   assign bus.max_q = maxQ;

   // Equal operands fall through to b, which is the same value as a.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         minQ <= '0;
         maxQ <= '0;
      end else if (bus.in_valid) begin
         minQ <= lt ? bus.a : bus.b;
         maxQ <= lt ? bus.b : bus.a;
      end
   end
`endif

endmodule

// File: tb/tb_comparator.sv
// Bench for comparator: unsigned and signed N=3 instances driven in lockstep,
// registered results tracked through a scoreboard queue.
module tb_comparator;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   typedef struct {
      logic [2:0] flagsU;
      logic [2:0] flagsS;
      logic       valid;
`ifdef COMPARATOR_MINMAX_EN
      logic [2:0] minU;
      logic [2:0] maxU;
      logic [2:0] minS;
      logic [2:0] maxS;
`endif
   } regExp_t;

   regExp_t sbQ[$];
   regExp_t model;

   comparator_if #(.N(3)) busU ();
   comparator_if #(.N(3)) busS ();

   comparator #(.N(3), .SIGNED(1'b0)) dutU (.clk(clk), .rst_n(rst_n), .bus(busU.slave));
   comparator #(.N(3), .SIGNED(1'b1)) dutS (.clk(clk), .rst_n(rst_n), .bus(busS.slave));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference ordering: {lt, eq, gt}
   function automatic logic [2:0] flagsOf(input logic [2:0] x, input logic [2:0] y, input bit sgn);
      if (sgn)
         return {$signed(x) < $signed(y), x == y, $signed(x) > $signed(y)};
      return {x < y, x == y, x > y};
   endfunction

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkRegs(input regExp_t e);
      checkOutput("u.flags_q", 8'({busU.lt_q, busU.eq_q, busU.gt_q}), 8'(e.flagsU));
      checkOutput("s.flags_q", 8'({busS.lt_q, busS.eq_q, busS.gt_q}), 8'(e.flagsS));
      checkOutput("u.out_valid", 8'(busU.out_valid), 8'(e.valid));
      checkOutput("s.out_valid", 8'(busS.out_valid), 8'(e.valid));
`ifdef COMPARATOR_MINMAX_EN
      checkOutput("u.min_q", 8'(busU.min_q), 8'(e.minU));
      checkOutput("u.max_q", 8'(busU.max_q), 8'(e.maxU));
      checkOutput("s.min_q", 8'(busS.min_q), 8'(e.minS));
      checkOutput("s.max_q", 8'(busS.max_q), 8'(e.maxS));
`endif
   endtask

   // Drive just after a posedge, check combinational flags at the negedge,
   // and retire the previous step's registered result.
   task automatic applyStimulus(input logic [2:0] aa, input logic [2:0] bb, input logic v);
      logic [2:0] fu;
      logic [2:0] fs;
      @(posedge clk);
      #1;
      busU.a = aa; busU.b = bb; busU.in_valid = v;
      busS.a = aa; busS.b = bb; busS.in_valid = v;
      fu = flagsOf(aa, bb, 1'b0);
      fs = flagsOf(aa, bb, 1'b1);
      if (v) begin
         model.flagsU = fu;
         model.flagsS = fs;
`ifdef COMPARATOR_MINMAX_EN
         model.minU = (aa < bb) ? aa : bb;
         model.maxU = (aa < bb) ? bb : aa;
         model.minS = ($signed(aa) < $signed(bb)) ? aa : bb;
         model.maxS = ($signed(aa) < $signed(bb)) ? bb : aa;
`endif
      end
      model.valid = v;
      sbQ.push_back(model);
      @(negedge clk);
      checkOutput("u.flags", 8'({busU.lt, busU.eq, busU.gt}), 8'(fu));
      checkOutput("s.flags", 8'({busS.lt, busS.eq, busS.gt}), 8'(fs));
      if (sbQ.size() > 1) checkRegs(sbQ.pop_front());
   endtask

   task automatic drain();
      @(posedge clk);
      #1;
      busU.in_valid = 1'b0;
      busS.in_valid = 1'b0;
      model.valid   = 1'b0;
      @(negedge clk);
      while (sbQ.size() > 0) checkRegs(sbQ.pop_front());
   endtask

   initial begin
      model = '{default: '0};
      busU.a = '0; busU.b = '0; busU.in_valid = 1'b0;
      busS.a = '0; busS.b = '0; busS.in_valid = 1'b0;

      #3;
      checkRegs(model);
      #9;
      rst_n = 1'b1;

      // Directed compares
      applyStimulus(3'd2, 3'd5, 1'b1);
      applyStimulus(3'd5, 3'd2, 1'b1);
      applyStimulus(3'd4, 3'd4, 1'b1);
      applyStimulus(3'b111, 3'b000, 1'b1);
      applyStimulus(3'b011, 3'b100, 1'b1);

      // Exhaustive sweep of all operand pairs
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            applyStimulus(3'(i), 3'(j), 1'b1);

      // Hold: flags keep the last capture while out_valid drops
      applyStimulus(3'd1, 3'd6, 1'b1);
      applyStimulus(3'd6, 3'd1, 1'b0);
      applyStimulus(3'd6, 3'd1, 1'b0);
      drain();

      // Asynchronous reset mid-cycle discards the in-flight result
      applyStimulus(3'd5, 3'd2, 1'b1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      sbQ.delete();
      model = '{default: '0};
      busU.in_valid = 1'b0;
      busS.in_valid = 1'b0;
      checkRegs(model);
      @(posedge clk);
      @(negedge clk);
      checkRegs(model);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkRegs(model);

      // Capture after release, including the min/max case
      applyStimulus(3'd2, 3'd5, 1'b1);
      applyStimulus(3'd6, 3'd3, 1'b1);
      applyStimulus(3'd3, 3'd3, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
